// File: rtl/pipelined_loop_controller_pkg.sv
// Shared types and constants for the pipelined loop controller.
// Holds the scheduler state encoding and the counter-width helper.
package pipelined_loop_controller_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int DEFAULT_W = 32;

    // A modulo-n counter needs at least one bit even when n is 1.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pipelined_loop_controller_if.sv
// Handshake between the parent control FSM and the loop scheduler,
// plus the per-iteration signals the scheduler presents to the datapath.
interface pipelined_loop_controller_if #(
    parameter int W = pipelined_loop_controller_pkg::DEFAULT_W
);
    logic         start;
    logic         stall;
    logic         issue;
    logic [W-1:0] iter;
    logic         first_iter;
    logic         last_iter;
    logic         busy;
    logic         done;

    modport master (
        output start,
        output stall,
        input  issue,
        input  iter,
        input  first_iter,
        input  last_iter,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  stall,
        output issue,
        output iter,
        output first_iter,
        output last_iter,
        output busy,
        output done
    );
endinterface

// File: rtl/pipelined_loop_controller_ii_tick_gen.sv
// Modulo-II counter with synchronous clear and enable; tick marks the
// cycles on which the counter sits at zero.
module pipelined_loop_controller_ii_tick_gen
    import pipelined_loop_controller_pkg::*;
#(
    parameter int II = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tick
);
    localparam int            CW   = cnt_width(II);
    localparam logic [CW-1:0] LAST = CW'(II - 1);

    logic [CW-1:0] ii_cnt;

    if (II < 1) begin : g_bad_ii
        $error("II must be at least 1");
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            ii_cnt <= '0;
        end else if (enable) begin
            ii_cnt <= (ii_cnt == LAST) ? '0 : ii_cnt + 1'b1;
        end
    end

    assign tick = (ii_cnt == '0);

endmodule

// File: rtl/pipelined_loop_controller.sv
// Scheduler for one pipelined loop: issues TRIP_COUNT iterations spaced II
// enabled cycles apart, then waits DEPTH enabled cycles before signalling done.
module pipelined_loop_controller
    import pipelined_loop_controller_pkg::*;
#(
    parameter int TRIP_COUNT = 8,
    parameter int II         = 1,
    parameter int DEPTH      = 3,
    parameter int W          = DEFAULT_W
) (
    input  logic                          clk,
    input  logic                          rst,
    pipelined_loop_controller_if.slave    bus
);
    localparam int            DW         = cnt_width(DEPTH);
    localparam logic [W-1:0]  LAST_ITER  = W'(TRIP_COUNT - 1);
    localparam logic [DW-1:0] LAST_DRAIN = DW'(DEPTH - 1);

    if (TRIP_COUNT < 1) begin : g_bad_trip
        $error("TRIP_COUNT must be at least 1");
    end
    if (DEPTH < 1) begin : g_bad_depth
        $error("DEPTH must be at least 1");
    end
    if (W < 31 && TRIP_COUNT > (1 << W)) begin : g_bad_width
        $error("TRIP_COUNT does not fit in W bits");
    end

    state_t        state;
    logic [W-1:0]  iter;
    logic [DW-1:0] drain_cnt;
    logic          busy_q;
    logic          tick;
    logic          in_issue;
    logic          in_drain;
    logic          issue_now;
    logic          last_now;
    logic          done_now;

    assign in_issue = (state == ISSUE);
    assign in_drain = (state == DRAIN);

    // Held at zero outside ISSUE so every run starts with an immediate issue.
    pipelined_loop_controller_ii_tick_gen #(
        .II (II)
    ) u_ii_tick_gen (
        .clk    (clk),
        .rst    (rst),
        .clear  (!in_issue),
        .enable (in_issue && !bus.stall),
        .tick   (tick)
    );

    assign issue_now = in_issue && tick && !bus.stall;
    assign last_now  = issue_now && (iter == LAST_ITER);
    assign done_now  = in_drain && (drain_cnt == LAST_DRAIN) && !bus.stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            iter      <= '0;
            drain_cnt <= '0;
            busy_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state  <= ISSUE;
                        iter   <= '0;
                        busy_q <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (last_now) begin
                        state     <= DRAIN;
                        iter      <= '0;
                        drain_cnt <= '0;
                    end else if (issue_now) begin
                        iter <= iter + 1'b1;
                    end
                end
                DRAIN: begin
                    if (done_now) begin
                        state     <= IDLE;
                        drain_cnt <= '0;
                        busy_q    <= 1'b0;
                    end else if (!bus.stall) begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.issue      = issue_now;
    assign bus.iter       = iter;
    assign bus.first_iter = issue_now && (iter == '0);
    assign bus.last_iter  = last_now;
    assign bus.busy       = busy_q;
    assign bus.done       = done_now;

endmodule

// File: tb/tb_pipelined_loop_controller.sv
// Self-checking bench: three controller configurations share start/stall/rst
// and are compared every cycle against an enabled-cycle schedule model.
module tb_pipelined_loop_controller;

    localparam int NDUT = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic stall = 1'b0;

    int cyc = 0;
    int n_vec = 0;
    int n_miss = 0;

    bit m_active [NDUT];
    int m_e      [NDUT];

    logic        act_issue [NDUT];
    logic [31:0] act_iter  [NDUT];
    logic        act_first [NDUT];
    logic        act_last  [NDUT];
    logic        act_busy  [NDUT];
    logic        act_done  [NDUT];

    logic [12:0] a_issue_m;
    logic [12:0] a_done_m;
    logic [12:0] a_busy_m;
    logic [12:0] b_issue_m;
    logic [12:0] b_done_m;
    logic [12:0] b_busy_m;

    always #5 clk = ~clk;

    pipelined_loop_controller_if #(.W(32)) bus_a ();
    pipelined_loop_controller_if #(.W(32)) bus_b ();
    pipelined_loop_controller_if #(.W(3))  bus_c ();

    assign bus_a.start = start;
    assign bus_a.stall = stall;
    assign bus_b.start = start;
    assign bus_b.stall = stall;
    assign bus_c.start = start;
    assign bus_c.stall = stall;

    pipelined_loop_controller #(.TRIP_COUNT(3), .II(2), .DEPTH(2), .W(32)) dut_a (
        .clk (clk), .rst (rst), .bus (bus_a)
    );
    pipelined_loop_controller #(.TRIP_COUNT(4), .II(1), .DEPTH(1), .W(32)) dut_b (
        .clk (clk), .rst (rst), .bus (bus_b)
    );
    pipelined_loop_controller #(.TRIP_COUNT(8), .II(1), .DEPTH(3), .W(3)) dut_c (
        .clk (clk), .rst (rst), .bus (bus_c)
    );

    assign act_issue[0] = bus_a.issue;
    assign act_iter[0]  = bus_a.iter;
    assign act_first[0] = bus_a.first_iter;
    assign act_last[0]  = bus_a.last_iter;
    assign act_busy[0]  = bus_a.busy;
    assign act_done[0]  = bus_a.done;
    assign act_issue[1] = bus_b.issue;
    assign act_iter[1]  = bus_b.iter;
    assign act_first[1] = bus_b.first_iter;
    assign act_last[1]  = bus_b.last_iter;
    assign act_busy[1]  = bus_b.busy;
    assign act_done[1]  = bus_b.done;
    assign act_issue[2] = bus_c.issue;
    assign act_iter[2]  = {29'b0, bus_c.iter};
    assign act_first[2] = bus_c.first_iter;
    assign act_last[2]  = bus_c.last_iter;
    assign act_busy[2]  = bus_c.busy;
    assign act_done[2]  = bus_c.done;

    function automatic int cfg_tc(input int d);
        return (d == 0) ? 3 : (d == 1) ? 4 : 8;
    endfunction

    function automatic int cfg_ii(input int d);
        return (d == 0) ? 2 : 1;
    endfunction

    function automatic int cfg_depth(input int d);
        return (d == 0) ? 2 : (d == 1) ? 1 : 3;
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        n_vec++;
        if (actual !== expected) begin
            n_miss++;
            $display("[TB] FAIL %s at cycle %0d: got %0d, want %0d",
                     name, cyc, actual, expected);
        end
    endtask

    // The model counts non-stalled cycles since the run was accepted: issue k
    // lands on enabled cycle k*II and done lands DEPTH enabled cycles after
    // the last issue.
    task automatic model_check();
        for (int d = 0; d < NDUT; d++) begin
            int   tc     = cfg_tc(d);
            int   ii     = cfg_ii(d);
            int   dp     = cfg_depth(d);
            int   last_e = (tc - 1) * ii;
            int   x_iter = m_e[d] / ii;
            logic x_issue;
            logic x_done;
            x_issue = m_active[d] && !stall && (m_e[d] % ii == 0) && (m_e[d] <= last_e);
            x_done  = m_active[d] && !stall && (m_e[d] == last_e + dp);
            check_output($sformatf("d%0d_issue", d), 32'(act_issue[d]), 32'(x_issue));
            check_output($sformatf("d%0d_busy", d), 32'(act_busy[d]), 32'(m_active[d]));
            check_output($sformatf("d%0d_done", d), 32'(act_done[d]), 32'(x_done));
            check_output($sformatf("d%0d_first", d), 32'(act_first[d]),
                         32'(x_issue && x_iter == 0));
            check_output($sformatf("d%0d_last", d), 32'(act_last[d]),
                         32'(x_issue && x_iter == tc - 1));
            if (x_issue) begin
                check_output($sformatf("d%0d_iter", d), act_iter[d], 32'(x_iter));
            end
            if (rst) begin
                m_active[d] = 1'b0;
                m_e[d]      = 0;
            end else if (!m_active[d]) begin
                if (start) begin
                    m_active[d] = 1'b1;
                    m_e[d]      = 0;
                end
            end else if (!stall) begin
                if (x_done) m_active[d] = 1'b0;
                else        m_e[d]      = m_e[d] + 1;
            end
        end
    endtask

    task automatic apply_stimulus(input logic s, input logic st, input logic r);
        @(posedge clk);
        #1;
        start = s;
        stall = st;
        rst   = r;
        #3;
        model_check();
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            apply_stimulus(1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        a_issue_m = 13'h02A;
        a_done_m  = 13'h080;
        a_busy_m  = 13'h0FE;
        b_issue_m = 13'h79E;
        b_done_m  = 13'h820;
        b_busy_m  = 13'hFBE;
        for (int d = 0; d < NDUT; d++) begin
            m_active[d] = 1'b0;
            m_e[d]      = 0;
        end

        for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 1'b0, 1'b1);
        apply_stimulus(1'b0, 1'b0, 1'b0);
        check_output("reset_a_busy", 32'(act_busy[0]), 32'd0);
        check_output("reset_a_issue", 32'(act_issue[0]), 32'd0);
        check_output("reset_c_done", 32'(act_done[2]), 32'd0);
        idle_cycles(2);

        $display("[TB] scenario: no stall, back-to-back start on short config");
        for (int k = 0; k < 13; k++) begin
            cyc = k;
            apply_stimulus(k == 0 || k == 5 || k == 6, 1'b0, 1'b0);
            check_output("s1_a_issue", 32'(act_issue[0]), 32'(a_issue_m[k]));
            check_output("s1_a_done", 32'(act_done[0]), 32'(a_done_m[k]));
            check_output("s1_a_busy", 32'(act_busy[0]), 32'(a_busy_m[k]));
            check_output("s1_b_issue", 32'(act_issue[1]), 32'(b_issue_m[k]));
            check_output("s1_b_done", 32'(act_done[1]), 32'(b_done_m[k]));
            check_output("s1_b_busy", 32'(act_busy[1]), 32'(b_busy_m[k]));
            if (k == 1) begin
                check_output("s1_a_iter0", act_iter[0], 32'd0);
                check_output("s1_a_first", 32'(act_first[0]), 32'd1);
            end
            if (k == 3) check_output("s1_a_iter1", act_iter[0], 32'd1);
            if (k == 5) begin
                check_output("s1_a_iter2", act_iter[0], 32'd2);
                check_output("s1_a_last", 32'(act_last[0]), 32'd1);
            end
            if (k == 4) check_output("s1_b_last", 32'(act_last[1]), 32'd1);
            if (k == 7) begin
                check_output("s1_b_restart_iter", act_iter[1], 32'd0);
                check_output("s1_b_restart_first", 32'(act_first[1]), 32'd1);
            end
        end
        idle_cycles(5);

        $display("[TB] scenario: stall during the issue phase");
        for (int k = 0; k < 12; k++) begin
            cyc = k;
            apply_stimulus(k == 0, k == 2 || k == 3, 1'b0);
            check_output("s2_a_issue", 32'(act_issue[0]), 32'(k == 1 || k == 5 || k == 7));
            check_output("s2_a_done", 32'(act_done[0]), 32'(k == 9));
            check_output("s2_a_busy", 32'(act_busy[0]), 32'(k >= 1 && k <= 9));
            if (k == 5) check_output("s2_a_iter1", act_iter[0], 32'd1);
            if (k == 7) begin
                check_output("s2_a_iter2", act_iter[0], 32'd2);
                check_output("s2_a_last", 32'(act_last[0]), 32'd1);
            end
        end
        idle_cycles(20);

        $display("[TB] scenario: reset mid-run then restart");
        for (int k = 0; k < 10; k++) begin
            cyc = k;
            apply_stimulus(k == 0 || k == 6, 1'b0, k == 4);
            if (k == 3) check_output("s3_c_iter2", act_iter[2], 32'd2);
            if (k == 5) begin
                check_output("s3_c_busy", 32'(act_busy[2]), 32'd0);
                check_output("s3_c_issue", 32'(act_issue[2]), 32'd0);
                check_output("s3_c_done", 32'(act_done[2]), 32'd0);
            end
            if (k == 7) begin
                check_output("s3_c_restart_issue", 32'(act_issue[2]), 32'd1);
                check_output("s3_c_restart_iter", act_iter[2], 32'd0);
                check_output("s3_c_restart_first", 32'(act_first[2]), 32'd1);
            end
        end
        idle_cycles(20);

        $display("[TB] scenario: randomized start/stall/reset");
        for (int k = 0; k < 800; k++) begin
            cyc = k;
            apply_stimulus($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                           $urandom_range(0, 99) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/pipelined_loop_controller.md
Name: pipelined_loop_controller

Overview:
Sequences one pipelined loop. It issues TRIP_COUNT iterations into a datapath, one every II enabled cycles, then waits DEPTH cycles for the pipeline to drain before reporting completion. It is the scheduler that drives the per-iteration counters and II-spaced activity signals of a loop body.
It sits between the parent control FSM (start/done) and the loop datapath (issue, iter, stall).

Parameters:
TRIP_COUNT, 8, number of iterations per run; must be >= 1 (elaboration-time check)
II, 1, initiation interval in enabled cycles; must be >= 1
DEPTH, 3, pipeline latency from last issue to done; must be >= 1
W, 32, width of the iteration index; TRIP_COUNT <= 2^W

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
start  in  1  run request; sampled only in IDLE
stall  in  1  datapath stall; freezes all counters and suppresses issue/done
issue  out  1  launch one iteration this cycle
iter  out  W  index of the iteration being issued; meaningful only while issue=1
first_iter  out  1  issue & (iter == 0)
last_iter  out  1  issue & (iter == TRIP_COUNT-1)
busy  out  1  high in ISSUE and DRAIN
done  out  1  single-cycle completion pulse

Behaviour:
- Reset: state IDLE, ii_cnt=0, iter=0, drain_cnt=0. issue, first_iter, last_iter, busy and done are all 0.
- Reset mid-run aborts immediately. No done pulse is produced, and the next start begins from iter 0.
- IDLE:
  - busy=0.
  - start=1 moves to ISSUE next cycle with ii_cnt=0 and iter=0.
  - stall has no effect on start acceptance.
- ISSUE:
  - issue = (ii_cnt == 0) & !stall. issue, first_iter, last_iter and done are combinational from registered state and stall.
  - ii_cnt advances 0..II-1 and wraps on each !stall cycle.
  - On each issue, iter increments.
  - On the issue where iter == TRIP_COUNT-1, go to DRAIN next cycle with drain_cnt=0. iter resets to 0 and ii_cnt is discarded.
- DRAIN:
  - drain_cnt increments on each !stall cycle.
  - done = (drain_cnt == DEPTH-1) & !stall. The same condition returns the FSM to IDLE next cycle.
- Latency, no stall:
  - first issue = start cycle + 1
  - issue k occurs at start + 1 + k*II
  - done = last issue + DEPTH
- Stall: freezes ii_cnt, iter and drain_cnt. It stretches the schedule by exactly one cycle per stalled cycle.
- start while busy is ignored, including in the done cycle.
- start in the first IDLE cycle after done is accepted (back-to-back runs).
- II=1: issue every non-stalled ISSUE cycle.
- iter arithmetic is unsigned W-bit and never wraps, because TRIP_COUNT <= 2^W.

Decomposition:
- Shared package:
  - state enum IDLE/ISSUE/DRAIN
  - default index width constant (32)
- Sub-module ii_tick_gen: modulo-II counter with clear and enable. Its tick output is ii_cnt==0. It is instantiated once for ii_cnt.
- The FSM, iter counter and drain_cnt counter are in the top module.

Test Plan:
- TRIP_COUNT=3, II=2, DEPTH=2, start at cycle 0, no stall -> issue at cycles 1/3/5 with iter 0/1/2; first_iter at 1; last_iter at 5; done at 7; busy cycles 1-7.
- Same configuration, stall high at cycles 2-3 -> issues at 1/5/7; done at 9; iter holds during the stall.
- II=1, TRIP_COUNT=4, DEPTH=1 -> issue at cycles 1-4 with iter 0-3; done at 5. A second start at cycle 6 gives issue at 7 with iter=0.
- start pulsed at cycles 3 and 6 during a run -> both ignored; done count = 1.
- rst asserted at cycle 4 of a TRIP_COUNT=8 run -> cycle 5 shows IDLE, busy=0 and no done. A later start restarts at iter 0.
- start in the done cycle -> ignored. start the following cycle -> accepted, issue one cycle later.
